watchdog_supervisor: RTL and testbench

//  Sequencing controller for the 4-bit Watchdog timer: drives its enable/restart, watches its timeout.

---
 rtl/watchdog_supervisor.sv | 165 ++++++++++++++++
 tb/tb_watchdog_supervisor.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watchdog_supervisor.sv
// Supervisor for the 4-bit Watchdog: keyed two-beat kicks, early-kick window,
// escalation from warning IRQ to a held system reset request.
//
// state | meaning
// IDLE  | watchdog disabled, waiting for cfg_start
// ARMED | watchdog running, kicks accepted after the window opens
// WARN  | first timeout seen, irq_warn raised, any valid kick recovers
// BITE  | reset requested, waiting for rst_ack
module watchdog_supervisor #(
   parameter int               KEY_W    = 8,
   parameter logic [KEY_W-1:0] KEY1     = 8'h55,
   parameter logic [KEY_W-1:0] KEY2     = 8'hAA,
   parameter int               MIN_KICK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic             kick_valid,
   input  logic [KEY_W-1:0] kick_data,
   output logic             kick_ready,
   output logic             wdt_enable,
   output logic             wdt_restart,
   input  logic             wdt_timeout,
   output logic             irq_warn,
   output logic             rst_req,
   input  logic             rst_ack,
   output logic [1:0]       fault_code,
   output logic [1:0]       state
);

   localparam int               WIN_W    = $clog2(MIN_KICK + 1);
   localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(MIN_KICK);

   localparam logic [1:0] F_NONE    = 2'd0;
   localparam logic [1:0] F_TIMEOUT = 2'd1;
   localparam logic [1:0] F_EARLY   = 2'd2;
   localparam logic [1:0] F_BADKEY  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_WARN  = 2'd2,
      S_BITE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             key2_q, key2_d;
   logic [WIN_W-1:0] win_left_q, win_left_d;
   logic             wdt_enable_q, wdt_enable_d;
   logic             wdt_restart_q, wdt_restart_d;
   logic             kick_ready_q, kick_ready_d;
   logic             irq_warn_q, irq_warn_d;
   logic             rst_req_q, rst_req_d;
   logic [1:0]       fault_q, fault_d;

   logic accept, beat_ok, kick_done, bad_key, timeout_seen, win_open;

   always_comb begin
      state_d       = state_q;
      key2_d        = key2_q;
      irq_warn_d    = irq_warn_q;
      fault_d       = fault_q;
      wdt_restart_d = 1'b0;

      accept       = kick_valid & kick_ready_q;
      beat_ok      = key2_q ? (kick_data == KEY2) : (kick_data == KEY1);
      kick_done    = accept & key2_q & beat_ok;
      bad_key      = accept & ~beat_ok;
      // The watchdog still shows its old count during the restart cycle.
      timeout_seen = wdt_timeout & ~wdt_restart_q;
      win_open     = (win_left_q == '0);

      if (accept) key2_d = ~key2_q & beat_ok;

      case (state_q)
         S_IDLE: begin
            if (cfg_start) begin
               state_d       = S_ARMED;
               fault_d       = F_NONE;
               wdt_restart_d = 1'b1;
            end
         end
         S_ARMED: begin
            if (bad_key) begin
               state_d = S_BITE;
               fault_d = F_BADKEY;
            end else if (kick_done) begin
               if (!win_open) begin
                  state_d = S_BITE;
                  fault_d = F_EARLY;
               end else begin
                  wdt_restart_d = 1'b1;
               end
            end else if (timeout_seen) begin
               state_d       = S_WARN;
               irq_warn_d    = 1'b1;
               wdt_restart_d = 1'b1;
            end
         end
         S_WARN: begin
            if (bad_key) begin
               state_d = S_BITE;
               fault_d = F_BADKEY;
            end else if (kick_done) begin
               state_d       = S_ARMED;
               irq_warn_d    = 1'b0;
               wdt_restart_d = 1'b1;
            end else if (timeout_seen) begin
               state_d = S_BITE;
               fault_d = F_TIMEOUT;
            end
         end
         S_BITE: begin
            if (rst_ack) begin
               state_d    = S_IDLE;
               irq_warn_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_BITE || state_d == S_IDLE) key2_d = 1'b0;

      if (wdt_restart_d)        win_left_d = WIN_LOAD;
      else if (win_left_q != 0) win_left_d = win_left_q - WIN_W'(1);
      else                      win_left_d = win_left_q;

      wdt_enable_d = (state_d == S_ARMED) || (state_d == S_WARN);
      kick_ready_d = wdt_enable_d;
      rst_req_d    = (state_d == S_BITE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         key2_q        <= 1'b0;
         win_left_q    <= WIN_LOAD;
         wdt_enable_q  <= 1'b0;
         wdt_restart_q <= 1'b0;
         kick_ready_q  <= 1'b0;
         irq_warn_q    <= 1'b0;
         rst_req_q     <= 1'b0;
         fault_q       <= F_NONE;
      end else begin
         state_q       <= state_d;
         key2_q        <= key2_d;
         win_left_q    <= win_left_d;
         wdt_enable_q  <= wdt_enable_d;
         wdt_restart_q <= wdt_restart_d;
         kick_ready_q  <= kick_ready_d;
         irq_warn_q    <= irq_warn_d;
         rst_req_q     <= rst_req_d;
         fault_q       <= fault_d;
      end
   end

   assign state       = state_q;
   assign kick_ready  = kick_ready_q;
   assign wdt_enable  = wdt_enable_q;
   assign wdt_restart = wdt_restart_q;
   assign irq_warn    = irq_warn_q;
   assign rst_req     = rst_req_q;
   assign fault_code  = fault_q;

endmodule

// File: tb/tb_watchdog_supervisor.sv
// Bench for watchdog_supervisor: directed scenarios plus random traffic, with a
// per-cycle reference model feeding a scoreboard queue and a 4-bit watchdog stand-in.
module tb_watchdog_supervisor;

   localparam int         MIN_KICK = 4;
   localparam logic [7:0] KEY1     = 8'h55;
   localparam logic [7:0] KEY2     = 8'hAA;

   logic       clk = 1'b0;
   logic       rst, cfg_start, kick_valid, rst_ack;
   logic [7:0] kick_data;
   logic       kick_ready, wdt_enable, wdt_restart, wdt_timeout;
   logic       irq_warn, rst_req;
   logic [1:0] fault_code, state;

   always #5 clk = ~clk;

   watchdog_supervisor #(
      .KEY_W(8), .KEY1(KEY1), .KEY2(KEY2), .MIN_KICK(MIN_KICK)
   ) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start),
      .kick_valid(kick_valid), .kick_data(kick_data), .kick_ready(kick_ready),
      .wdt_enable(wdt_enable), .wdt_restart(wdt_restart), .wdt_timeout(wdt_timeout),
      .irq_warn(irq_warn), .rst_req(rst_req), .rst_ack(rst_ack),
      .fault_code(fault_code), .state(state)
   );

   // Watchdog stand-in: restart at edge E0 gives count 0, timeout after E15, saturating.
   logic [3:0] wd_cnt = 4'd0;
   always @(posedge clk) begin
      if (!wdt_enable || wdt_restart) wd_cnt <= 4'd0;
      else if (wd_cnt != 4'd15)       wd_cnt <= wd_cnt + 4'd1;
   end
   assign wdt_timeout = wdt_enable && (wd_cnt == 4'd15);

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
      end
   endtask

   typedef struct packed {
      logic [1:0] st;
      logic [1:0] fc;
      logic       en;
      logic       rs;
      logic       rd;
      logic       iq;
      logic       rq;
   } exp_t;

   exp_t sb_q[$];

   // Reference model: mode 0 idle, 1 armed, 2 warn, 3 bite; m_since counts cycles since restart.
   int   m_mode = 0;
   int   m_fault = 0;
   int   m_since = MIN_KICK;
   bit   m_key1 = 1'b0;
   bit   m_irq = 1'b0;
   bit   m_restart = 1'b0;
   bit   m_accept, m_good, m_bad, m_tmo, m_rs_now;
   exp_t m_e;

   task go_bite(input int code);
      m_mode  = 3;
      m_fault = code;
      m_key1  = 1'b0;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_mode    = 0;
         m_fault   = 0;
         m_since   = MIN_KICK;
         m_key1    = 1'b0;
         m_irq     = 1'b0;
         m_restart = 1'b0;
      end else begin
         m_accept = kick_valid && (m_mode == 1 || m_mode == 2);
         m_good   = m_accept && m_key1 && (kick_data == KEY2);
         m_bad    = m_accept && !(m_key1 ? (kick_data == KEY2) : (kick_data == KEY1));
         m_tmo    = wdt_timeout && !m_restart;
         m_rs_now = 1'b0;
         if (m_accept) m_key1 = !m_key1 && (kick_data == KEY1);
         if (m_mode == 0) begin
            if (cfg_start) begin
               m_mode   = 1;
               m_fault  = 0;
               m_rs_now = 1'b1;
            end
         end else if (m_mode == 3) begin
            if (rst_ack) begin
               m_mode = 0;
               m_irq  = 1'b0;
               m_key1 = 1'b0;
            end
         end else begin
            if (m_bad) go_bite(3);
            else if (m_good && m_mode == 1 && m_since < MIN_KICK) go_bite(2);
            else if (m_good) begin
               m_mode   = 1;
               m_irq    = 1'b0;
               m_rs_now = 1'b1;
            end else if (m_tmo && m_mode == 1) begin
               m_mode   = 2;
               m_irq    = 1'b1;
               m_rs_now = 1'b1;
            end else if (m_tmo) go_bite(1);
         end
         if (m_rs_now)           m_since = 0;
         else if (m_since < 1000) m_since = m_since + 1;
         m_restart = m_rs_now;
      end
      m_e.st = 2'(m_mode);
      m_e.fc = 2'(m_fault);
      m_e.en = (m_mode == 1 || m_mode == 2);
      m_e.rd = (m_mode == 1 || m_mode == 2);
      m_e.rq = (m_mode == 3);
      m_e.rs = m_restart;
      m_e.iq = m_irq;
      sb_q.push_back(m_e);
   end

   exp_t mon_e;
   always @(negedge clk) begin
      if (sb_q.size() != 0) begin
         mon_e = sb_q.pop_front();
         chk("sb_state", int'(state), int'(mon_e.st));
         chk("sb_fault", int'(fault_code), int'(mon_e.fc));
         chk("sb_enable", int'(wdt_enable), int'(mon_e.en));
         chk("sb_restart", int'(wdt_restart), int'(mon_e.rs));
         chk("sb_ready", int'(kick_ready), int'(mon_e.rd));
         chk("sb_irq", int'(irq_warn), int'(mon_e.iq));
         chk("sb_rst_req", int'(rst_req), int'(mon_e.rq));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [7:0] d);
      kick_valid = 1'b1;
      kick_data  = d;
      tick();
      kick_valid = 1'b0;
   endtask

   task automatic wait_state(input int s, input int bound, output int n);
      n = 0;
      while (int'(state) != s && n < bound) begin
         tick();
         n++;
      end
   endtask

   int         n;
   int         rate;
   int         r;
   logic [7:0] next_key;

   initial begin
      rst = 1'b1; cfg_start = 1'b0; kick_valid = 1'b0; kick_data = 8'h00; rst_ack = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      chk("reset_state", int'(state), 0);
      chk("reset_enable", int'(wdt_enable), 0);
      chk("reset_rst_req", int'(rst_req), 0);
      chk("reset_ready", int'(kick_ready), 0);

      // arm
      cfg_start = 1'b1; tick(); cfg_start = 1'b0;
      chk("t1_state", int'(state), 1);
      chk("t1_enable", int'(wdt_enable), 1);
      chk("t1_restart", int'(wdt_restart), 1);
      chk("t1_fault", int'(fault_code), 0);
      tick();
      chk("t1_restart_pulse", int'(wdt_restart), 0);

      // regular kicks every 10 cycles
      for (int k = 0; k < 10; k++) begin
         repeat (8) tick();
         beat(KEY1);
         beat(KEY2);
         chk("t2_restart", int'(wdt_restart), 1);
         chk("t2_state", int'(state), 1);
         chk("t2_irq", int'(irq_warn), 0);
      end

      // no kicks: warn then bite
      n = 0;
      while (!irq_warn && n < 40) begin tick(); n++; end
      chk("t3_warn_delay", n, 17);
      chk("t3_warn_state", int'(state), 2);
      chk("t3_warn_restart", int'(wdt_restart), 1);
      wait_state(3, 40, n);
      chk("t3_bite_delay", n, 17);
      chk("t3_rst_req", int'(rst_req), 1);
      chk("t3_fault", int'(fault_code), 1);
      chk("t3_enable", int'(wdt_enable), 0);
      chk("t3_irq_held", int'(irq_warn), 1);
      rst_ack = 1'b1; tick(); rst_ack = 1'b0;
      chk("t3_idle", int'(state), 0);
      chk("t3_rst_req_clr", int'(rst_req), 0);
      chk("t3_irq_clr", int'(irq_warn), 0);
      chk("t3_fault_held", int'(fault_code), 1);

      // recover from WARN
      cfg_start = 1'b1; tick(); cfg_start = 1'b0;
      chk("t4_fault_clr", int'(fault_code), 0);
      wait_state(2, 40, n);
      chk("t4_warn", int'(state), 2);
      beat(KEY1);
      beat(KEY2);
      chk("t4_state", int'(state), 1);
      chk("t4_irq", int'(irq_warn), 0);
      chk("t4_restart", int'(wdt_restart), 1);
      chk("t4_fault", int'(fault_code), 0);

      // bad key, then early kick
      beat(KEY1);
      beat(8'h3C);
      chk("t5_badkey_state", int'(state), 3);
      chk("t5_badkey_fault", int'(fault_code), 3);
      chk("t5_badkey_rst_req", int'(rst_req), 1);
      rst_ack = 1'b1; tick(); rst_ack = 1'b0;
      cfg_start = 1'b1; tick(); cfg_start = 1'b0;
      beat(KEY1);
      beat(KEY2);
      chk("t5_early_state", int'(state), 3);
      chk("t5_early_fault", int'(fault_code), 2);
      rst_ack = 1'b1; tick(); rst_ack = 1'b0;

      // kick completes in the timeout cycle, then rst during BITE
      cfg_start = 1'b1; tick(); cfg_start = 1'b0;
      beat(KEY1);
      n = 0;
      while (!wdt_timeout && n < 40) begin tick(); n++; end
      chk("t6_timeout_seen", int'(wdt_timeout), 1);
      kick_valid = 1'b1; kick_data = KEY2; tick(); kick_valid = 1'b0;
      chk("t6_state", int'(state), 1);
      chk("t6_irq", int'(irq_warn), 0);
      chk("t6_restart", int'(wdt_restart), 1);
      wait_state(3, 100, n);
      chk("t6_bite", int'(state), 3);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t6_rst_state", int'(state), 0);
      chk("t6_rst_rst_req", int'(rst_req), 0);
      chk("t6_rst_irq", int'(irq_warn), 0);
      chk("t6_rst_fault", int'(fault_code), 0);
      chk("t6_rst_enable", int'(wdt_enable), 0);

      // random traffic
      rate = 4;
      next_key = KEY1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 250 == 0) rate = $urandom_range(1, 14);
         rst        = ($urandom_range(0, 799) == 0);
         cfg_start  = ($urandom_range(0, 7) == 0);
         rst_ack    = ($urandom_range(0, 5) == 0);
         kick_valid = ($urandom_range(0, rate) == 0);
         r          = $urandom_range(0, 31);
         if (r == 0)      kick_data = 8'($urandom);
         else if (r == 1) kick_data = KEY1;
         else             kick_data = next_key;
         if (rst || !kick_ready) next_key = KEY1;
         else if (kick_valid)
            next_key = (next_key == KEY1 && kick_data == KEY1) ? KEY2 : KEY1;
         tick();
      end
      rst = 1'b0; cfg_start = 1'b0; kick_valid = 1'b0; rst_ack = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
